lsu_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the core's memory-stage control signals (mem_wren/mem_op from the control decoder, ALU address, rs2 data) and a data memory with a request/grant/response handshake.
- Stalls the core while an access is in flight.
- Generates byte enables and lane-replicated write data.
- Extracts and sign/zero-extends load data.
- Aborts hung accesses with a watchdog timeout.

---
 rtl/lsu_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- multi-cycle load/store sequencer between the memory-stage
// control signals and a request/grant/response data memory.
//
// Stalls the core while an access is in flight, builds byte enables and
// lane-replicated store data, sign/zero-extends load data and aborts a hung
// access with a watchdog (TIMEOUT_CYCLES = 0 disables the watchdog).
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to make misaligned H/W
// requests complete in two cycles with err_o instead of being aligned down.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i/req_wren_i/req_op_i core request: valid, store(1)/load(0),
//   req_addr_i/req_wdata_i          funct3, byte address, store data
//   stall_o                         freeze PC/pipeline (combinational)
//   done_o/err_o/ld_data_o          completion pulse, abort flag, load data
//   dmem_req_o/we_o/addr_o/be_o/    memory request side (registered)
//   wdata_o
//   dmem_gnt_i/rvalid_i/rdata_i     memory grant and read response
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_wren_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] ld_data_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;
  logic             trap_hit;

  // Access attributes captured on acceptance; data-only, so not reset.
  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic             we_q;

  // Size is taken from funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic [3:0] be_gen(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = 4'b0011 << {off[1], 1'b0};
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] op, input logic [31:0] w);
    case (op[1:0])
      2'b00:   wdata_rep = {4{w[7:0]}};
      2'b01:   wdata_rep = {2{w[15:0]}};
      default: wdata_rep = w;
    endcase
  endfunction

  // Half loads ignore a[0] and word loads ignore a[1:0], which gives the
  // align-down behaviour for misaligned accesses.
  function automatic logic [31:0] ld_extend(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [31:0] sh;
    case (op[1:0])
      2'b00: begin
        sh        = rdata >> {off, 3'b000};
        ld_extend = op[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh        = rdata >> {off[1], 4'b0000};
        ld_extend = op[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: ld_extend = rdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = misaligned(req_op_i, req_addr_i[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  // The count equals the number of REQ/WAIT cycles already spent, so the
  // last allowed cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign wd_expire = WD_EN && (wd_cnt == CNT_LAST);

  assign stall_o = ((state == S_IDLE) && req_valid_i) || (state == S_REQ) || (state == S_WAIT);

  always_ff @(posedge clk_i) begin
    if ((state == S_IDLE) && req_valid_i) begin
      op_q  <= req_op_i;
      off_q <= req_addr_i[1:0];
      we_q  <= req_wren_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      wd_cnt       <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      ld_data_o    <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        // Accept a request and present it to memory from the next cycle.
        S_IDLE: begin
          if (req_valid_i) begin
            if (trap_hit) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              err_o     <= 1'b1;
              ld_data_o <= '0;
            end else begin
              state        <= S_REQ;
              wd_cnt       <= '0;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= req_wren_i;
              dmem_addr_o  <= {req_addr_i[31:2], 2'b00};
              dmem_be_o    <= be_gen(req_op_i, req_addr_i[1:0]);
              dmem_wdata_o <= wdata_rep(req_op_i, req_wdata_i);
            end
          end
        end
        // Hold the request stable until granted; a grant beats the timeout.
        S_REQ: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            if (we_q) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              ld_data_o <= '0;
            end else begin
              state <= S_WAIT;
            end
          end else if (wd_expire) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            state      <= S_DONE;
            done_o     <= 1'b1;
            err_o      <= 1'b1;
            ld_data_o  <= '0;
          end
        end
        // Wait for read data; rvalid beats the timeout in the same cycle.
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (dmem_rvalid_i) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            ld_data_o <= ld_extend(op_q, off_q, dmem_rdata_i);
          end else if (wd_expire) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            ld_data_o <= '0;
          end
        end
        // Completion cycle: core is released, next request accepted in IDLE.
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_wren;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall_o, done_o, err_o;
  logic [31:0] ld_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_wren_i(req_wren), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .ld_data_o(ld_data_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, set by the stimulus.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_done, exp_err, exp_we;
  logic [31:0] exp_ld, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] model_ld = 32'h0;

  // Observations from the last access.
  int          n_stall, done_idx, req_cyc, done_cyc;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- reference model (access-level rules) ----------------
  function automatic int sz_of(input logic [2:0] op);
    return op[1] ? 4 : (op[0] ? 2 : 1);
  endfunction

  function automatic int lane_off(input logic [2:0] op, input logic [31:0] a);
    int s = sz_of(op);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
    int s = sz_of(op);
    int m = (s == 1) ? 1 : ((s == 2) ? 3 : 15);
    return 4'(m << lane_off(op, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] w);
    int s = sz_of(op);
    if (s == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (s == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] rd);
    int s = sz_of(op);
    logic [31:0] v, mask;
    if (s == 4) return rd;
    mask = (s == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * lane_off(op, a))) & mask;
    if (!op[2] && v[s*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic m_misal(input logic [2:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % sz_of(op)) != 0;
  endfunction

  // Compare process: every cycle while enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall_o, exp_stall);
      chk("dmem_req", dmem_req_o, exp_req);
      chk("done", done_o, exp_done);
      chk("err", err_o, exp_err);
      chk("ld_data", ld_data_o, exp_ld);
      if (exp_req) begin
        chk("dmem_we", dmem_we_o, exp_we);
        chk("dmem_addr", dmem_addr_o, exp_addr);
        chk("dmem_be", dmem_be_o, exp_be);
        chk("dmem_wdata", dmem_wdata_o, exp_wdata);
      end
    end
  end

  task automatic end_cycle(input int idx);
    @(negedge clk);
    if (stall_o) n_stall++;
    if (dmem_req_o && req_cyc < 0) begin
      req_cyc    = cyc;
      seen_addr  = dmem_addr_o;
      seen_be    = dmem_be_o;
      seen_wdata = dmem_wdata_o;
    end
    if (done_o) begin
      done_idx = idx;
      done_cyc = cyc;
      seen_err = err_o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_ld = model_ld;
    for (int k = 0; k < n; k++) end_cycle(-1);
  endtask

  // gd: REQ cycle index carrying gnt (>= TMO means never); rd: cycles from
  // gnt to rvalid; noise drives gnt/rvalid where the design must ignore them.
  task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gd, input int rd,
                        input logic [31:0] rdata, input logic noise);
    int n_req, n_wait;
    logic granted, got, err, trap;
    logic [31:0] new_ld;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = m_misal(op, addr);
`endif
    granted = !trap && (gd <= TMO - 1);
    n_req   = trap ? 0 : (granted ? gd + 1 : TMO);
    got     = granted && !we && (gd + rd <= TMO - 1);
    n_wait  = (!granted || we) ? 0 : (got ? rd : TMO - n_req);
    err     = trap || !granted || (!we && !got);
    new_ld  = (!we && !err) ? m_ext(op, addr, rdata) : 32'h0;
    n_stall = 0; done_idx = -1; req_cyc = -1; seen_err = 1'b0;
    seen_addr = 32'h0; seen_be = 4'h0; seen_wdata = 32'h0;

    req_valid = 1'b1; req_wren = we; req_op = op; req_addr = addr; req_wdata = wdata;
    dmem_gnt = 1'b0; dmem_rvalid = noise; dmem_rdata = ~rdata;
    exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_ld = model_ld;
    exp_we = we; exp_addr = {addr[31:2], 2'b00}; exp_be = m_be(op, addr);
    exp_wdata = m_wdata(op, wdata);
    end_cycle(0);
    for (int i = 0; i < n_req; i++) begin
      exp_req = 1'b1;
      dmem_gnt = granted && (i == gd);
      dmem_rvalid = noise;
      end_cycle(1 + i);
    end
    for (int j = 0; j < n_wait; j++) begin
      exp_req = 1'b0;
      dmem_gnt = noise;
      dmem_rvalid = got && (j == n_wait - 1);
      dmem_rdata = dmem_rvalid ? rdata : ~rdata;
      end_cycle(1 + n_req + j);
    end
    model_ld = new_ld;
    req_valid = 1'b0; dmem_gnt = noise; dmem_rvalid = noise;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1; exp_err = err; exp_ld = new_ld;
    end_cycle(1 + n_req + n_wait);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d1;
    rst_ni = 1'b0; req_valid = 1'b0; req_wren = 1'b0; req_op = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ld", ld_data_o, 32'h0);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_be", dmem_be_o, 4'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    #2 rst_ni = 1'b1;
    @(posedge clk); #1;
    model_ld = 32'h0;
    idle_cycles(1);
    chk_en = 1'b1;
    idle_cycles(2);

    // SW, grant in the first REQ cycle
    access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0);
    chk("sw_addr", seen_addr, 32'h104);
    chk("sw_be", seen_be, 4'b1111);
    chk("sw_wdata", seen_wdata, 32'hDEADBEEF);
    chk("sw_stall_cycles", n_stall, 2);
    chk("sw_done_idx", done_idx, 2);
    chk("sw_err", seen_err, 1'b0);

    // SB / SH lane replication
    access(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 32'h0, 1'b0);
    chk("sb_be", seen_be, 4'b1000);
    chk("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    access(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 1, 1, 32'h0, 1'b1);
    chk("sh_be", seen_be, 4'b1100);
    chk("sh_wdata", seen_wdata, 32'hBEEFBEEF);

    // Loads with sign/zero extension
    access(1'b0, 3'b000, 32'h102, 32'h0, 0, 3, 32'h0080FF00, 1'b0);
    chk("lb_ld", ld_data_o, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h102, 32'h0, 0, 3, 32'h0080FF00, 1'b0);
    chk("lbu_ld", ld_data_o, 32'h00000080);
    access(1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80011234, 1'b0);
    chk("lhu_ld", ld_data_o, 32'h00008001);
    chk("load_min_latency", done_idx, 3);
    access(1'b0, 3'b001, 32'h100, 32'h0, 0, 2, 32'hC0007FFF, 1'b1);
    chk("lh_ld", ld_data_o, 32'h00007FFF);
    access(1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'hC0007FFF, 1'b0);
    chk("lh_neg_ld", ld_data_o, 32'hFFFFC000);
    access(1'b0, 3'b011, 32'h208, 32'h0, 0, 1, 32'h89ABCDEF, 1'b0);
    chk("op011_ld", ld_data_o, 32'h89ABCDEF);

    // Delayed grant, then back-to-back second load
    access(1'b0, 3'b010, 32'h300, 32'h0, 4, 2, 32'h01020304, 1'b1);
    chk("dly_ld", ld_data_o, 32'h01020304);
    d1 = done_cyc;
    access(1'b0, 3'b000, 32'h301, 32'h0, 0, 1, 32'h01020304, 1'b0);
    chk("b2b_gap", req_cyc - d1, 2);
    chk("b2b_ld", ld_data_o, 32'h00000003);

    // Grant in the very last allowed cycle wins over the watchdog
    access(1'b1, 3'b010, 32'h400, 32'h55AA55AA, TMO - 1, 1, 32'h0, 1'b0);
    chk("gnt_last_err", seen_err, 1'b0);

    // Store that is never granted: aborts after TMO REQ cycles
    access(1'b0, 3'b010, 32'h500, 32'h0, 0, 1, 32'h77777777, 1'b0);
    access(1'b1, 3'b010, 32'h504, 32'h12345678, 1000, 1, 32'h0, 1'b0);
    chk("tmo_err", seen_err, 1'b1);
    chk("tmo_done_idx", done_idx, TMO + 1);
    chk("tmo_ld", ld_data_o, 32'h0);
    idle_cycles(2);

    // Load whose read data never arrives: aborts in WAIT
    access(1'b0, 3'b010, 32'h600, 32'h0, 2, 20, 32'h0, 1'b0);
    chk("wait_tmo_err", seen_err, 1'b1);

    // Misaligned word load
    access(1'b0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h11223344, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("trap_no_req", req_cyc, -1);
    chk("trap_err", seen_err, 1'b1);
    chk("trap_done_idx", done_idx, 1);
`else
    chk("misal_addr", seen_addr, 32'h100);
    chk("misal_ld", ld_data_o, 32'h11223344);
`endif

    // Asynchronous reset while waiting for read data; late rvalid ignored
    chk_en = 1'b0;
    req_valid = 1'b1; req_wren = 1'b0; req_op = 3'b010; req_addr = 32'h200;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1 rst_ni = 1'b0; req_valid = 1'b0;
    #1;
    chk("rstw_stall", stall_o, 1'b0);
    chk("rstw_ld", ld_data_o, 32'h0);
    chk("rstw_done", done_o, 1'b0);
    chk("rstw_we", dmem_we_o, 1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #2 rst_ni = 1'b1;
    @(posedge clk); #1;
    model_ld = 32'h0;
    chk_en = 1'b1;
    idle_cycles(2);
    dmem_rvalid = 1'b0;
    idle_cycles(1);

    // Asynchronous reset during REQ drops the request at once
    chk_en = 1'b0;
    req_valid = 1'b1; req_wren = 1'b1; req_op = 3'b010; req_addr = 32'h300;
    @(posedge clk); #1;
    chk("rstq_req_before", dmem_req_o, 1'b1);
    rst_ni = 1'b0; req_valid = 1'b0;
    #1;
    chk("rstq_req_drop", dmem_req_o, 1'b0);
    chk("rstq_stall", stall_o, 1'b0);
    @(posedge clk); #2 rst_ni = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle_cycles(2);
    access(1'b1, 3'b010, 32'h700, 32'hFEEDFACE, 0, 1, 32'h0, 1'b0);
    chk("post_rst_wdata", seen_wdata, 32'hFEEDFACE);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
